// File: rtl/sram_port_arbiter_if.sv
// Bundle of per-channel request/response lines and the single-port SRAM pins
// shared by the arbiter (slave side) and whatever drives the channels and models the SRAM (master side).
interface sram_port_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*BE_W-1:0]   ch_we;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_gnt;
  logic [NUM_CH-1:0]        ch_rvalid;
  logic [DATA_W-1:0]        ch_rdata;
  logic                     sram_cs;
  logic                     sram_oe;
  logic [BE_W-1:0]          sram_web;
  logic [ADDR_W-1:0]        sram_a;
  logic [DATA_W-1:0]        sram_di;
  logic [DATA_W-1:0]        sram_do;

  modport master (
    output ch_req, ch_we, ch_addr, ch_wdata, sram_do,
    input  ch_gnt, ch_rvalid, ch_rdata, sram_cs, sram_oe, sram_web, sram_a, sram_di
  );

  modport slave (
    input  ch_req, ch_we, ch_addr, ch_wdata, sram_do,
    output ch_gnt, ch_rvalid, ch_rdata, sram_cs, sram_oe, sram_web, sram_a, sram_di
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Arbitrates NUM_CH request channels onto one single-port synchronous SRAM.
// Grant and SRAM drive are combinational; read data returns to the winner one cycle later.
module sram_port_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int BE_W     = DATA_W / 8,
  parameter int ARB_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  sram_port_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_CH);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  cand;
  logic              gnt_any;
  logic [BE_W-1:0]   win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              vld_p1;
  logic [PTR_W-1:0]  rd_ch_p1;

  function automatic logic [NUM_CH-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_CH - 1) ? '0 : p + 1'b1;
  endfunction

  // Winner search: scan starts at rr_ptr (round-robin) or at 0 (fixed priority).
  always_comb begin
    gnt_any = 1'b0;
    win     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == 0) cand = PTR_W'((int'(rr_ptr) + k) % NUM_CH);
      else               cand = PTR_W'(k);
      if (!gnt_any && bus.ch_req[cand]) begin
        gnt_any = 1'b1;
        win     = cand;
      end
    end
    // Reset masks grants so nothing reaches the SRAM or the pending-read stage.
    if (!rst) gnt_any = 1'b0;
  end

  always_comb begin
    win_we    = bus.ch_we[int'(win)*BE_W +: BE_W];
    win_addr  = bus.ch_addr[int'(win)*ADDR_W +: ADDR_W];
    win_wdata = bus.ch_wdata[int'(win)*DATA_W +: DATA_W];
  end

  always_comb begin
    bus.ch_gnt    = gnt_any ? onehot(win) : '0;
    bus.sram_cs   = gnt_any;
    bus.sram_oe   = 1'b1;
    bus.sram_web  = gnt_any ? ~win_we   : '1;
    bus.sram_a    = gnt_any ? win_addr  : '0;
    bus.sram_di   = gnt_any ? win_wdata : '0;
    bus.ch_rvalid = vld_p1 ? onehot(rd_ch_p1) : '0;
    bus.ch_rdata  = vld_p1 ? bus.sram_do : '0;
  end

  // Stage p0 -> p1: remember which channel owns the read data arriving next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      vld_p1   <= 1'b0;
      rd_ch_p1 <= '0;
    end else begin
      if (gnt_any) rr_ptr <= wrap_inc(win);
      vld_p1   <= gnt_any && (win_we == '0);
      rd_ch_p1 <= win;
    end
  end
endmodule
